// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - request_unit handshake bundle; REQ_STATS_EN adds instr_cnt/stall_cnt
interface request_unit_if;
    logic        ihit;
    logic        dhit;
    logic        memREN;
    logic        memWEN;
    logic        halt_in;
    logic        iREN;
    logic        dREN;
    logic        dWEN;
    logic        pc_en;
    logic        halt;
    logic        timeout_err;
`ifdef REQ_STATS_EN
    logic [31:0] instr_cnt;
    logic [31:0] stall_cnt;

    modport master (
        input  ihit, dhit, memREN, memWEN, halt_in,
        output iREN, dREN, dWEN, pc_en, halt, timeout_err, instr_cnt, stall_cnt
    );
    modport slave (
        output ihit, dhit, memREN, memWEN, halt_in,
        input  iREN, dREN, dWEN, pc_en, halt, timeout_err, instr_cnt, stall_cnt
    );
`else
    modport master (
        input  ihit, dhit, memREN, memWEN, halt_in,
        output iREN, dREN, dWEN, pc_en, halt, timeout_err
    );
    modport slave (
        output ihit, dhit, memREN, memWEN, halt_in,
        input  iREN, dREN, dWEN, pc_en, halt, timeout_err
    );
`endif
endinterface

// File: rtl/request_unit.sv
// rtl/request_unit.sv - memory request sequencer with data watchdog; REQ_STATS_EN adds counters
module request_unit #(
    parameter int TIMEOUT_W = 8
) (
    input  logic          CLK,
    input  logic          RST,
    request_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, DATA, HALTED, ERR} state_t;

    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    state_t               state_q, state_d;
    logic                 iren_q, iren_d;
    logic                 dren_q, dren_d;
    logic                 dwen_q, dwen_d;
    logic                 halt_q, halt_d;
    logic                 terr_q, terr_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 pc_en;

    always_comb begin
        state_d = state_q;
        iren_d  = iren_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        halt_d  = halt_q;
        terr_d  = terr_q;
        wd_d    = wd_q;
        pc_en   = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.ihit) begin
                    if (bus.halt_in) begin
                        state_d = HALTED;
                        iren_d  = 1'b0;
                        halt_d  = 1'b1;
                    end else if (bus.memREN && bus.memWEN) begin
                        state_d = ERR;
                        iren_d  = 1'b0;
                        halt_d  = 1'b1;
                        terr_d  = 1'b1;
                    end else if (bus.memREN || bus.memWEN) begin
                        state_d = DATA;
                        iren_d  = 1'b0;
                        dren_d  = bus.memREN;
                        dwen_d  = bus.memWEN;
                        wd_d    = '0;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DATA: begin
                // dhit on the final watchdog cycle still completes the access
                if (bus.dhit) begin
                    pc_en   = 1'b1;
                    state_d = FETCH;
                    iren_d  = 1'b1;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                end else if (wd_q == WD_MAX - 1'b1) begin
                    state_d = ERR;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    halt_d  = 1'b1;
                    terr_d  = 1'b1;
                    wd_d    = WD_MAX;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            iren_q  <= 1'b1;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            halt_q  <= 1'b0;
            terr_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            iren_q  <= iren_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            halt_q  <= halt_d;
            terr_q  <= terr_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.iREN        = iren_q;
    assign bus.dREN        = dren_q;
    assign bus.dWEN        = dwen_q;
    assign bus.pc_en       = pc_en;
    assign bus.halt        = halt_q;
    assign bus.timeout_err = terr_q;

`ifdef REQ_STATS_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // HALTED/ERR produce neither pc_en nor stall, so the counters freeze there
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall       = ((state_q == FETCH) && !bus.ihit) || ((state_q == DATA) && !bus.dhit);
        if (pc_en) instr_cnt_d = instr_cnt_q + 32'd1;
        if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.instr_cnt = instr_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
